// File: rtl/uart_cmd_arbiter_pkg.sv
// Shared types and defaults for the UART command arbiter.
// Holds the FSM state encoding, the write-select value of the command MSB and default sizes.
package uart_cmd_arbiter_pkg;

  localparam int DEF_NUM_REQ     = 4;
  localparam int DEF_CMD_WIDTH   = 16;
  localparam int DEF_READ_WIDTH  = 8;
  localparam int DEF_TIMEOUT_CYC = 65535;

  // Value of the command MSB (bit CMD_WIDTH-1) that selects a write.
  localparam logic CMD_WRITE = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_WAIT_BUSY = 3'd2,
    ST_WAIT_WR   = 3'd3,
    ST_WAIT_RD   = 3'd4
  } state_t;

endpackage

// File: rtl/uart_cmd_arbiter_if.sv
// Command/read-back handshake between the arbiter (master) and the UART command engine (slave).
interface uart_cmd_arbiter_if
  import uart_cmd_arbiter_pkg::*;
#(
  parameter int CMD_WIDTH  = DEF_CMD_WIDTH,
  parameter int READ_WIDTH = DEF_READ_WIDTH
) ();

  logic [CMD_WIDTH-1:0]  uart_cmd;
  logic                  uart_cmd_vld;
  logic                  uart_cmd_rdy;
  logic                  uart_read_rdy;
  logic [READ_WIDTH-1:0] uart_read_data;

  modport master (
    output uart_cmd,
    output uart_cmd_vld,
    input  uart_cmd_rdy,
    input  uart_read_rdy,
    input  uart_read_data
  );

  modport slave (
    input  uart_cmd,
    input  uart_cmd_vld,
    output uart_cmd_rdy,
    output uart_read_rdy,
    output uart_read_data
  );

endinterface

// File: rtl/uart_cmd_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request scanning ptr+1, ptr+2, ... modulo NUM_REQ.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   win,
  output logic               any
);

  int idx;

  always_comb begin
    gnt = '0;
    win = '0;
    any = 1'b0;
    idx = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!any && req[idx]) begin
        any      = 1'b1;
        win      = idx[IDX_W-1:0];
        gnt[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_cmd_arbiter.sv
// Round-robin arbiter sharing one UART command engine between NUM_REQ requesters,
// tracking each transaction to completion or timeout and returning the response to its owner.
module uart_cmd_arbiter
  import uart_cmd_arbiter_pkg::*;
#(
  parameter int NUM_REQ     = DEF_NUM_REQ,
  parameter int CMD_WIDTH   = DEF_CMD_WIDTH,
  parameter int READ_WIDTH  = DEF_READ_WIDTH,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ*CMD_WIDTH-1:0]  req_cmd,
  input  logic [NUM_REQ-1:0]            req_vld,
  output logic [NUM_REQ-1:0]            req_rdy,
  output logic [NUM_REQ-1:0]            rsp_vld,
  output logic [READ_WIDTH-1:0]         rsp_data,
  output logic                          rsp_err,
  uart_cmd_arbiter_if.master            uart
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  state_t                state;
  logic [IDX_W-1:0]      ptr;
  logic [IDX_W-1:0]      owner;
  logic [CMD_WIDTH-1:0]  cmd_buf;
  logic [CNT_W-1:0]      cnt;
  logic [CMD_WIDTH-1:0]  cmd_out;
  logic                  cmd_vld_out;

  logic [NUM_REQ-1:0]    gnt;
  logic [IDX_W-1:0]      win;
  logic                  any;
  logic [CMD_WIDTH-1:0]  win_cmd;
  logic [NUM_REQ-1:0]    owner_onehot;
  logic                  timed_out;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req (req_vld),
    .ptr (ptr),
    .gnt (gnt),
    .win (win),
    .any (any)
  );

  assign win_cmd      = req_cmd[int'(win)*CMD_WIDTH +: CMD_WIDTH];
  assign owner_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << owner;
  assign timed_out    = (cnt == CNT_W'(TIMEOUT_CYC));

  // The accept strobe is gated by rst_n so nothing is granted while reset is held.
  assign req_rdy = (state == ST_IDLE && rst_n) ? gnt : '0;

  assign uart.uart_cmd     = cmd_out;
  assign uart.uart_cmd_vld = cmd_vld_out;

  // In every waiting state a real completion event takes priority over the timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      ptr         <= IDX_W'(NUM_REQ - 1);
      owner       <= '0;
      cmd_buf     <= '0;
      cnt         <= '0;
      cmd_out     <= '0;
      cmd_vld_out <= 1'b0;
      rsp_vld     <= '0;
      rsp_data    <= '0;
      rsp_err     <= 1'b0;
    end else begin
      rsp_vld  <= '0;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
      if (state != ST_IDLE && !timed_out) begin
        cnt <= cnt + 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (any) begin
            cmd_buf     <= win_cmd;
            cmd_out     <= win_cmd;
            cmd_vld_out <= 1'b1;
            owner       <= win;
            ptr         <= win;
            cnt         <= '0;
            state       <= ST_ISSUE;
          end
        end

        ST_ISSUE: begin
          if (uart.uart_cmd_rdy) begin
            cmd_vld_out <= 1'b0;
            state       <= ST_WAIT_BUSY;
          end else if (timed_out) begin
            cmd_vld_out <= 1'b0;
            rsp_vld     <= owner_onehot;
            rsp_err     <= 1'b1;
            state       <= ST_IDLE;
          end
        end

        ST_WAIT_BUSY: begin
          if (!uart.uart_cmd_rdy) begin
            state <= (cmd_buf[CMD_WIDTH-1] == CMD_WRITE) ? ST_WAIT_WR : ST_WAIT_RD;
          end else if (timed_out) begin
            rsp_vld <= owner_onehot;
            rsp_err <= 1'b1;
            state   <= ST_IDLE;
          end
        end

        ST_WAIT_WR: begin
          if (uart.uart_cmd_rdy) begin
            rsp_vld <= owner_onehot;
            state   <= ST_IDLE;
          end else if (timed_out) begin
            rsp_vld <= owner_onehot;
            rsp_err <= 1'b1;
            state   <= ST_IDLE;
          end
        end

        ST_WAIT_RD: begin
          if (uart.uart_read_rdy) begin
            rsp_vld  <= owner_onehot;
            rsp_data <= uart.uart_read_data;
            state    <= ST_IDLE;
          end else if (timed_out) begin
            rsp_vld <= owner_onehot;
            rsp_err <= 1'b1;
            state   <= ST_IDLE;
          end
        end

        default: begin
          cmd_vld_out <= 1'b0;
          state       <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_arbiter.sv
// Directed bench for uart_cmd_arbiter: write, read, round-robin order, timeouts,
// completion-vs-timeout tie and asynchronous reset in the middle of a read.
module tb_uart_cmd_arbiter;

  localparam int NR = 4;
  localparam int CW = 16;
  localparam int RW = 8;
  localparam int TO = 50;

  logic              clk;
  logic              rst_n;
  logic [NR*CW-1:0]  req_cmd;
  logic [NR-1:0]     req_vld;
  logic [NR-1:0]     req_rdy;
  logic [NR-1:0]     rsp_vld;
  logic [RW-1:0]     rsp_data;
  logic              rsp_err;

  int checks = 0;
  int errors = 0;

  uart_cmd_arbiter_if #(.CMD_WIDTH(CW), .READ_WIDTH(RW)) uif ();

  uart_cmd_arbiter #(
    .NUM_REQ     (NR),
    .CMD_WIDTH   (CW),
    .READ_WIDTH  (RW),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_cmd  (req_cmd),
    .req_vld  (req_vld),
    .req_rdy  (req_rdy),
    .rsp_vld  (rsp_vld),
    .rsp_data (rsp_data),
    .rsp_err  (rsp_err),
    .uart     (uif.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [NR-1:0] vld, input logic cmd_rdy,
                               input logic rd_rdy, input logic [RW-1:0] rd_data);
    req_vld            = vld;
    uif.uart_cmd_rdy   = cmd_rdy;
    uif.uart_read_rdy  = rd_rdy;
    uif.uart_read_data = rd_data;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  // One write transaction with the fastest legal engine: accept, handshake, busy, done.
  task automatic serveWrite(input int idx, input logic [CW-1:0] cmd);
    checkOutput("rr_grant", 32'(req_rdy), 32'(1) << idx);
    cyc();
    checkOutput("rr_cmd", 32'(uif.uart_cmd), 32'(cmd));
    cyc();
    uif.uart_cmd_rdy = 1'b0;
    cyc();
    uif.uart_cmd_rdy = 1'b1;
    cyc();
    checkOutput("rr_rsp", 32'(rsp_vld), 32'(1) << idx);
  endtask

  initial begin
    req_cmd = '0;
    rst_n   = 1'b1;
    applyStimulus(4'hF, 1'b1, 1'b0, 8'h00);
    rst_n = 1'b0;
    cyc();
    cyc();
    $display("[TB] reset");
    checkOutput("reset_req_rdy", 32'(req_rdy), 32'h0);
    checkOutput("reset_cmd_vld", 32'(uif.uart_cmd_vld), 32'h0);
    checkOutput("reset_rsp_vld", 32'(rsp_vld), 32'h0);
    checkOutput("reset_uart_cmd", 32'(uif.uart_cmd), 32'h0);
    applyStimulus(4'h0, 1'b1, 1'b0, 8'h00);
    rst_n = 1'b1;

    $display("[TB] single write from requester 2");
    req_cmd[2*CW +: CW] = 16'h80A5;
    applyStimulus(4'b0100, 1'b1, 1'b0, 8'h00);
    checkOutput("wr_grant", 32'(req_rdy), 32'h4);
    cyc();
    applyStimulus(4'b0000, 1'b1, 1'b0, 8'h00);
    checkOutput("wr_rdy_drop", 32'(req_rdy), 32'h0);
    checkOutput("wr_cmd_vld", 32'(uif.uart_cmd_vld), 32'h1);
    checkOutput("wr_cmd", 32'(uif.uart_cmd), 32'h80A5);
    cyc();
    applyStimulus(4'b0000, 1'b0, 1'b0, 8'h00);
    checkOutput("wr_vld_drop", 32'(uif.uart_cmd_vld), 32'h0);
    repeat (20) cyc();
    checkOutput("wr_no_early_rsp", 32'(rsp_vld), 32'h0);
    applyStimulus(4'b0000, 1'b1, 1'b0, 8'h00);
    cyc();
    checkOutput("wr_rsp_vld", 32'(rsp_vld), 32'h4);
    checkOutput("wr_rsp_err", 32'(rsp_err), 32'h0);
    checkOutput("wr_rsp_data", 32'(rsp_data), 32'h0);
    cyc();
    checkOutput("wr_rsp_pulse", 32'(rsp_vld), 32'h0);

    $display("[TB] single read from requester 1");
    req_cmd[1*CW +: CW] = 16'h0012;
    applyStimulus(4'b0010, 1'b1, 1'b0, 8'h00);
    checkOutput("rd_grant", 32'(req_rdy), 32'h2);
    cyc();
    applyStimulus(4'b0000, 1'b1, 1'b0, 8'h00);
    checkOutput("rd_cmd", 32'(uif.uart_cmd), 32'h0012);
    cyc();
    applyStimulus(4'b0000, 1'b0, 1'b0, 8'h00);
    cyc();
    cyc();
    applyStimulus(4'b0000, 1'b0, 1'b1, 8'h3C);
    cyc();
    applyStimulus(4'b0000, 1'b1, 1'b0, 8'h00);
    checkOutput("rd_rsp_vld", 32'(rsp_vld), 32'h2);
    checkOutput("rd_rsp_data", 32'(rsp_data), 32'h3C);
    checkOutput("rd_rsp_err", 32'(rsp_err), 32'h0);

    $display("[TB] stray read_rdy while idle");
    applyStimulus(4'b0000, 1'b1, 1'b1, 8'hEE);
    cyc();
    applyStimulus(4'b0000, 1'b1, 1'b0, 8'h00);
    checkOutput("stray_rsp_vld", 32'(rsp_vld), 32'h0);
    checkOutput("stray_cmd_vld", 32'(uif.uart_cmd_vld), 32'h0);

    $display("[TB] round-robin with all requesters valid from reset");
    rst_n = 1'b0;
    req_cmd[0*CW +: CW] = 16'h8100;
    req_cmd[1*CW +: CW] = 16'h8201;
    req_cmd[2*CW +: CW] = 16'h8302;
    req_cmd[3*CW +: CW] = 16'h8403;
    applyStimulus(4'hF, 1'b1, 1'b0, 8'h00);
    cyc();
    rst_n = 1'b1;
    #1;
    serveWrite(0, 16'h8100);
    serveWrite(1, 16'h8201);
    serveWrite(2, 16'h8302);
    serveWrite(3, 16'h8403);
    serveWrite(0, 16'h8100);

    $display("[TB] timeout on a read in WAIT_RD, then on a write stuck in ISSUE");
    req_cmd[1*CW +: CW] = 16'h0011;
    req_cmd[2*CW +: CW] = 16'h8022;
    applyStimulus(4'b0110, 1'b1, 1'b0, 8'h00);
    checkOutput("to_grant", 32'(req_rdy), 32'h2);
    cyc();
    applyStimulus(4'b0100, 1'b1, 1'b0, 8'h00);
    cyc();
    applyStimulus(4'b0100, 1'b0, 1'b0, 8'h00);
    repeat (TO - 1) cyc();
    checkOutput("to_no_early_rsp", 32'(rsp_vld), 32'h0);
    cyc();
    checkOutput("to_rsp_vld", 32'(rsp_vld), 32'h2);
    checkOutput("to_rsp_err", 32'(rsp_err), 32'h1);
    checkOutput("to_rsp_data", 32'(rsp_data), 32'h0);
    checkOutput("to_next_grant", 32'(req_rdy), 32'h4);
    cyc();
    applyStimulus(4'b0000, 1'b0, 1'b0, 8'h00);
    checkOutput("to_issue_cmd", 32'(uif.uart_cmd), 32'h8022);
    checkOutput("to_issue_vld", 32'(uif.uart_cmd_vld), 32'h1);
    repeat (TO) cyc();
    checkOutput("to_issue_vld_held", 32'(uif.uart_cmd_vld), 32'h1);
    checkOutput("to_issue_no_early", 32'(rsp_vld), 32'h0);
    cyc();
    checkOutput("to_issue_vld_drop", 32'(uif.uart_cmd_vld), 32'h0);
    checkOutput("to_issue_rsp_vld", 32'(rsp_vld), 32'h4);
    checkOutput("to_issue_rsp_err", 32'(rsp_err), 32'h1);

    $display("[TB] read data arriving on the timeout cycle");
    req_cmd[3*CW +: CW] = 16'h0044;
    applyStimulus(4'b1000, 1'b1, 1'b0, 8'h00);
    checkOutput("sim_grant", 32'(req_rdy), 32'h8);
    cyc();
    applyStimulus(4'b0000, 1'b1, 1'b0, 8'h00);
    cyc();
    applyStimulus(4'b0000, 1'b0, 1'b0, 8'h00);
    repeat (TO - 1) cyc();
    applyStimulus(4'b0000, 1'b0, 1'b1, 8'h5A);
    cyc();
    applyStimulus(4'b0000, 1'b1, 1'b0, 8'h00);
    checkOutput("sim_rsp_vld", 32'(rsp_vld), 32'h8);
    checkOutput("sim_rsp_data", 32'(rsp_data), 32'h5A);
    checkOutput("sim_rsp_err", 32'(rsp_err), 32'h0);

    $display("[TB] asynchronous reset during WAIT_RD");
    req_cmd[2*CW +: CW] = 16'h0021;
    applyStimulus(4'b0100, 1'b1, 1'b0, 8'h00);
    checkOutput("rst_grant", 32'(req_rdy), 32'h4);
    cyc();
    applyStimulus(4'b0000, 1'b1, 1'b0, 8'h00);
    cyc();
    applyStimulus(4'b0000, 1'b0, 1'b0, 8'h00);
    cyc();
    cyc();
    checkOutput("rst_pre_cmd", 32'(uif.uart_cmd), 32'h0021);
    rst_n = 1'b0;
    applyStimulus(4'hF, 1'b0, 1'b0, 8'h00);
    checkOutput("rst_async_cmd", 32'(uif.uart_cmd), 32'h0);
    checkOutput("rst_async_vld", 32'(uif.uart_cmd_vld), 32'h0);
    checkOutput("rst_async_rsp", 32'(rsp_vld), 32'h0);
    checkOutput("rst_async_rdy", 32'(req_rdy), 32'h0);
    cyc();
    rst_n = 1'b1;
    applyStimulus(4'b0000, 1'b1, 1'b1, 8'h99);
    cyc();
    applyStimulus(4'b0000, 1'b1, 1'b0, 8'h00);
    checkOutput("rst_stray_rsp", 32'(rsp_vld), 32'h0);
    applyStimulus(4'hF, 1'b1, 1'b0, 8'h00);
    checkOutput("rst_first_grant", 32'(req_rdy), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_cmd_arbiter.md
# uart_cmd_arbiter

Round-robin arbiter that shares the single UART command engine (16-bit command in, bit 15 = write/read select, 8-bit read-back) between several requesters. It accepts one command at a time, drives the engine's `cmd_in`/`cmd_vld`/`cmd_rdy` handshake and tracks the transaction to completion. It then returns a completion (write) or read data (read) to the requester that owns the transaction, with a timeout so a stalled engine cannot lock out the other requesters. It sits between the host-side command sources and the UART engine.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `CMD_WIDTH`, 16: command width; MSB = 1 write, 0 read.
- `READ_WIDTH`, 8: read-back data width.
- `TIMEOUT_CYC`, 65535: wait-state cycles before abort, ≥ 2.

- `clk`  in  1  single clock; all logic on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req_cmd`  in  NUM_REQ*CMD_WIDTH  packed commands; requester i at `[i*CMD_WIDTH +: CMD_WIDTH]`.
- `req_vld`  in  NUM_REQ  per-requester command valid; held until accepted.
- `req_rdy`  out  NUM_REQ  one-hot accept strobe (combinational).
- `rsp_vld`  out  NUM_REQ  one-hot completion pulse, 1 cycle, registered.
- `rsp_data`  out  READ_WIDTH  read data; valid with `rsp_vld`; 0 for writes and errors.
- `rsp_err`  out  1  timeout flag; valid with `rsp_vld`.
- `uart_cmd`  out  CMD_WIDTH  command to engine, registered.
- `uart_cmd_vld`  out  1  command valid to engine, registered.
- `uart_cmd_rdy`  in  1  engine idle/ready.
- `uart_read_rdy`  in  1  engine read data valid.
- `uart_read_data`  in  READ_WIDTH  engine read data.

## Operation
- States: IDLE, ISSUE, WAIT_BUSY, WAIT_WR, WAIT_RD.
- IDLE: if any `req_vld`, the winner is the first set bit scanning `ptr+1, ptr+2, …` modulo NUM_REQ. Assert `req_rdy[win]`. At the clock edge: `cmd_buf <= req_cmd[win]`, `owner <= win`, `ptr <= win`, go to ISSUE. No `req_vld` → stay.
- ISSUE: `uart_cmd_vld = 1`, `uart_cmd = cmd_buf`. On `uart_cmd_rdy = 1`, the handshake completes and the state goes to WAIT_BUSY.
- WAIT_BUSY: wait for `uart_cmd_rdy = 0` (engine started). Then go to WAIT_WR if `cmd_buf[CMD_WIDTH-1]`, else WAIT_RD.
- WAIT_WR: on `uart_cmd_rdy = 1`:
  - pulse `rsp_vld[owner]` with `rsp_data = 0`, `rsp_err = 0`;
  - go to IDLE.
- WAIT_RD: on `uart_read_rdy = 1`:
  - pulse `rsp_vld[owner]` with `rsp_data = uart_read_data`, `rsp_err = 0`;
  - go to IDLE.
- Timeout: a 16-bit counter (width `$clog2(TIMEOUT_CYC+1)`) clears on entry to ISSUE, counts in ISSUE/WAIT_BUSY/WAIT_WR/WAIT_RD, and saturates.
  - When the count reaches TIMEOUT_CYC: pulse `rsp_vld[owner]` with `rsp_err = 1`, `rsp_data = 0`; drop `uart_cmd_vld`; go to IDLE.
- `uart_read_rdy` outside WAIT_RD is ignored; no response is generated.
- Reset values:
  - state IDLE, `ptr = NUM_REQ-1` (requester 0 has first priority);
  - `cmd_buf`, `owner`, counter = 0;
  - `uart_cmd = 0`, `uart_cmd_vld = 0`, `rsp_vld = 0`, `rsp_data = 0`, `rsp_err = 0`.
  - `req_rdy = 0` while `rst_n` is low.
- Reset mid-transaction: everything returns to reset values; the in-flight response is lost.

## Timing
- Accept latency: `req_rdy` is asserted in the same cycle that `req_vld` is seen in IDLE.
- `uart_cmd_vld` rises the next cycle. Earliest handshake is 1 cycle after accept.
- Response: `rsp_vld` is registered and appears 1 cycle after the completion event is sampled. That cycle is the first IDLE cycle, so a new grant may occur in the same cycle.
- Back-to-back: at most one transaction is in flight. Minimum per-transaction occupancy is 4 cycles plus engine time.
- Simultaneous completion event and timeout in the same cycle: the completion wins and `rsp_err = 0`.
- A requester whose `req_vld` deasserts before accept is simply not granted. The arbiter does not check that `req_vld` is held.
- Fairness: any continuously valid requester is granted within NUM_REQ transactions.

## Structure
- Shared package/include holds:
  - state localparams (3-bit encoding);
  - command MSB position (write = 1);
  - default TIMEOUT_CYC.
- Sub-module `rr_pick`: combinational round-robin priority selector (`req`, `ptr` → one-hot `gnt`, index `win`, `any`), parameterised by NUM_REQ.
- The FSM, `cmd_buf`, owner register, counter and response registers live in `uart_cmd_arbiter`.

## Test plan
- Single write: requester 2 sends `16'h80A5`; engine model holds `cmd_rdy` low for 20 cycles.
  - `req_rdy = 4'b0100` for 1 cycle; `uart_cmd = 16'h80A5` with `vld`.
  - `rsp_vld = 4'b0100`, `rsp_err = 0`, `rsp_data = 0`.
- Single read: requester 1 sends `16'h0012`; engine returns `8'h3C`.
  - `rsp_vld = 4'b0010`, `rsp_data = 8'h3C`, `rsp_err = 0`.
- Round-robin: all 4 requesters are valid continuously from reset.
  - Grant order is 0,1,2,3,0; each requester gets exactly one grant per four transactions.
- Timeout: `TIMEOUT_CYC = 50`; read issued and the engine never pulses `read_rdy`.
  - `rsp_vld[owner]` with `rsp_err = 1`, `rsp_data = 0`, 51 cycles after entering ISSUE.
  - The next pending requester is granted immediately after.
- Simultaneous: `read_rdy` arrives on the same cycle the count reaches TIMEOUT_CYC.
  - Data is returned with `rsp_err = 0`.
- Reset mid-operation: `rst_n` is pulsed low during WAIT_RD.
  - All outputs are 0 immediately (asynchronous); the stray `read_rdy` afterwards produces no `rsp_vld`.
  - The first grant after reset goes to requester 0.
